// File: rtl/spike_class_decoder.sv
// -----------------------------------------------------------------------------
// spike_class_decoder
//
// Readout stage behind the output LIF layer. It counts spikes per output neuron
// over a window of WINDOW_LEN enabled cycles. A sequential argmax scan then
// visits one neuron per cycle, and the winning class is presented with a
// valid/ready handshake.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start_i; result outputs hold the last result
//   ACCUM  | counting spikes on cycles with en_i=1 until the window completes
//   SCAN   | argmax over the counters, one neuron per cycle
//   DONE   | result valid; waits for ready_i
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        starts a window when idle
//   en_i           accumulate qualifier
//   spikes_i       spike vector, bit k = neuron k
//   ready_i        downstream accepts the result
//   class_valid_o  result valid
//   class_o        winning neuron index, zero-extended to 4 bits
//   max_count_o    spike count of the winner
//   tie_o          another neuron matched the winner's count
//   busy_o         high in any state other than IDLE
//
// Build option:
//   SPIKE_CLASS_DECODER_AUTORESTART_EN - when defined, a consumed result
//   starts the next window directly instead of returning to IDLE.
// -----------------------------------------------------------------------------
module spike_class_decoder #(
    parameter int NUM_OUTPUTS = 10,
    parameter int COUNT_W     = 8,
    parameter int WINDOW_LEN  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   en_i,
    input  logic [NUM_OUTPUTS-1:0] spikes_i,
    input  logic                   ready_i,
    output logic                   class_valid_o,
    output logic [3:0]             class_o,
    output logic [COUNT_W-1:0]     max_count_o,
    output logic                   tie_o,
    output logic                   busy_o
);

    localparam int IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int WIN_W = $clog2(WINDOW_LEN + 1);

`ifdef SPIKE_CLASS_DECODER_AUTORESTART_EN
    localparam bit AUTORESTART = 1'b1;
`else
    localparam bit AUTORESTART = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_OUTPUTS - 1);

    logic [1:0]         state_q,    state_d;
    logic [COUNT_W-1:0] cnt_q [NUM_OUTPUTS];
    logic [COUNT_W-1:0] cnt_d [NUM_OUTPUTS];
    logic [WIN_W-1:0]   win_cnt_q,  win_cnt_d;
    logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic [COUNT_W-1:0] best_q,     best_d;
    logic [IDX_W-1:0]   win_q,      win_d;
    logic               tie_q,      tie_d;
    logic [3:0]         class_q,    class_d;
    logic [COUNT_W-1:0] max_q,      max_d;
    logic               tie_out_q,  tie_out_d;
    logic               valid_q;
    logic               busy_q;

    logic               handshake;
    logic               clear_cnt;
    logic [COUNT_W-1:0] scan_cnt;

    assign handshake = (state_q == S_DONE) && ready_i;

    // Counters clear when a new window begins, either from IDLE or directly
    // out of DONE when autorestart is built in.
    assign clear_cnt = ((state_q == S_IDLE) && start_i) ||
                       (handshake && AUTORESTART);

    // Counter under the scan pointer; a compare-mux keeps the index width
    // independent of the array size when NUM_OUTPUTS is not a power of two.
    always_comb begin
        scan_cnt = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (scan_idx_q == IDX_W'(k)) begin
                scan_cnt = cnt_q[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        scan_idx_d = scan_idx_q;
        best_d     = best_q;
        win_d      = win_q;
        tie_d      = tie_q;
        class_d    = class_q;
        max_d      = max_q;
        tie_out_d  = tie_out_q;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            cnt_d[k] = cnt_q[k];
        end

        if (clear_cnt) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                cnt_d[k] = '0;
            end
            win_cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (en_i) begin
                    for (int k = 0; k < NUM_OUTPUTS; k++) begin
                        if (spikes_i[k] && (cnt_q[k] != CNT_MAX)) begin
                            cnt_d[k] = cnt_q[k] + COUNT_W'(1);
                        end
                    end
                    if (win_cnt_q == WIN_LAST) begin
                        state_d    = S_SCAN;
                        scan_idx_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                    end
                end
            end

            S_SCAN: begin
                if (scan_idx_q == '0) begin
                    best_d = scan_cnt;
                    win_d  = '0;
                    tie_d  = 1'b0;
                end else if (scan_cnt > best_q) begin
                    best_d = scan_cnt;
                    win_d  = scan_idx_q;
                    tie_d  = 1'b0;
                end else if (scan_cnt == best_q) begin
                    // Lowest index keeps the win; only the tie flag is raised.
                    tie_d = 1'b1;
                end

                if (scan_idx_q == IDX_LAST) begin
                    state_d              = S_DONE;
                    class_d              = '0;
                    class_d[IDX_W-1:0]   = win_d;
                    max_d                = best_d;
                    tie_out_d            = tie_d;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end

            S_DONE: begin
                if (handshake) begin
                    state_d = AUTORESTART ? S_ACCUM : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            win_cnt_q  <= '0;
            scan_idx_q <= '0;
            best_q     <= '0;
            win_q      <= '0;
            tie_q      <= 1'b0;
            class_q    <= '0;
            max_q      <= '0;
            tie_out_q  <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            scan_idx_q <= scan_idx_d;
            best_q     <= best_d;
            win_q      <= win_d;
            tie_q      <= tie_d;
            class_q    <= class_d;
            max_q      <= max_d;
            tie_out_q  <= tie_out_d;
            valid_q    <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign class_valid_o = valid_q;
    assign class_o       = class_q;
    assign max_count_o   = max_q;
    assign tie_o         = tie_out_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_spike_class_decoder.sv
module tb_spike_class_decoder;

    logic       clk = 1'b0;
    logic       rst_i, start_i, en_i, ready_i, start_s, ready_s;
    logic [9:0] spikes_i;

    logic       valid, tie, busy;
    logic [3:0] cls;
    logic [7:0] mx;
    logic       valid_s, tie_s, busy_s;
    logic [3:0] cls_s;
    logic [7:0] mx_s;

    spike_class_decoder dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .en_i(en_i),
        .spikes_i(spikes_i), .ready_i(ready_i),
        .class_valid_o(valid), .class_o(cls), .max_count_o(mx),
        .tie_o(tie), .busy_o(busy)
    );

    spike_class_decoder #(.NUM_OUTPUTS(10), .COUNT_W(8), .WINDOW_LEN(300)) dut_s (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_s), .en_i(en_i),
        .spikes_i(spikes_i), .ready_i(ready_s),
        .class_valid_o(valid_s), .class_o(cls_s), .max_count_o(mx_s),
        .tie_o(tie_s), .busy_o(busy_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] cls;
        logic [7:0] mx;
        logic       tie;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cs;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: every neuron whose bit is set spikes on all WINDOW_LEN enabled
    // cycles, counts saturate at 255, lowest index wins ties.
    function automatic exp_t model(input logic [9:0] pat, input int wlen, input int lat);
        int   c [10];
        exp_t e;
        for (int k = 0; k < 10; k++) c[k] = pat[k] ? ((wlen > 255) ? 255 : wlen) : 0;
        e.cls = 4'd0; e.mx = 8'(c[0]); e.tie = 1'b0; e.lat = lat;
        for (int k = 1; k < 10; k++) begin
            if (c[k] > int'(e.mx)) begin
                e.cls = 4'(k); e.mx = 8'(c[k]); e.tie = 1'b0;
            end else if (c[k] == int'(e.mx)) begin
                e.tie = 1'b1;
            end
        end
        return e;
    endfunction

    // Called just after a negedge; returns in cycle cs+1.
    task automatic start_window(input logic [9:0] pat, input bit push, input int lat);
        start_i  = 1'b1;
        spikes_i = pat;
        en_i     = 1'b1;
        cs       = cyc;
        if (push) sb.push_back(model(pat, 64, lat));
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Waits for valid on the selected DUT, pops the scoreboard and compares.
    // Returns at the negedge of the DONE cycle where valid was seen.
    task automatic wait_result(input string tag, input int maxc, input bit toggle, input bit sel);
        bit   found = 1'b0;
        exp_t e;
        for (int i = 0; i < maxc; i++) begin
            if ((sel ? valid_s : valid) === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (toggle) en_i = ((cyc - cs) % 2 == 1);
            @(negedge clk);
        end
        en_i = 1'b1;
        chk({tag, "_found"}, 32'(found), 32'd1);
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_class"}, 32'(sel ? cls_s : cls), 32'(e.cls));
            chk({tag, "_max"},   32'(sel ? mx_s : mx),   32'(e.mx));
            chk({tag, "_tie"},   32'(sel ? tie_s : tie), 32'(e.tie));
            chk({tag, "_lat"},   32'(cyc - cs),          32'(e.lat));
        end
    endtask

    initial begin
        logic [3:0] h_cls;
        logic [7:0] h_mx;
        logic       h_tie;
        int         n_valid;

        rst_i = 1'b1; start_i = 1'b0; en_i = 1'b0; ready_i = 1'b1;
        start_s = 1'b0; ready_s = 1'b1; spikes_i = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_class", 32'(cls),   32'd0);
        chk("rst_max",   32'(mx),    32'd0);
        chk("rst_tie",   32'(tie),   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);

`ifdef SPIKE_CLASS_DECODER_AUTORESTART_EN
        // Three back-to-back windows, only one start_i.
        start_window(10'b0000100000, 1'b1, 75);
        wait_result("ar0", 200, 1'b0, 1'b0);
        spikes_i = 10'b0000000010;
        cs = cyc + 1;
        sb.push_back(model(10'b0000000010, 64, 74));
        @(negedge clk);
        chk("ar_busy", 32'(busy), 32'd1);
        wait_result("ar1", 200, 1'b0, 1'b0);
        spikes_i = 10'b0100000000;
        cs = cyc + 1;
        sb.push_back(model(10'b0100000000, 64, 74));
        @(negedge clk);
        wait_result("ar2", 200, 1'b0, 1'b0);
        ready_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("ar_rst_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("ar_needs_start", 32'(busy), 32'd0);
`else
        // Single-neuron win with ready held high.
        start_window(10'b0000001000, 1'b1, 75);
        wait_result("single", 200, 1'b0, 1'b0);
        chk("single_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("single_valid_drop", 32'(valid), 32'd0);
        chk("single_busy_drop",  32'(busy),  32'd0);
        chk("single_retain",     32'(cls),   32'd3);

        // Tie between neurons 2 and 7.
        start_window(10'b0010000100, 1'b1, 75);
        wait_result("tie", 200, 1'b0, 1'b0);
        @(negedge clk);

        // en_i gaps: one enabled cycle in two.
        start_window(10'b0001000000, 1'b1, 138);
        wait_result("gaps", 300, 1'b1, 1'b0);
        @(negedge clk);

        // Backpressure with a start_i pulse inside DONE.
        ready_i = 1'b0;
        start_window(10'b0000100000, 1'b1, 75);
        wait_result("bp", 200, 1'b0, 1'b0);
        h_cls = cls; h_mx = mx; h_tie = tie;
        for (int i = 0; i < 20; i++) begin
            start_i = (i == 10);
            @(negedge clk);
            chk("bp_valid", 32'(valid), 32'd1);
            chk("bp_stable", {cls, mx, tie}, {h_cls, h_mx, h_tie});
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("bp_drop", 32'(valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_idle", 32'(busy), 32'd0);
        ready_i = 1'b1;

        // Reset mid-window (window cycle 30).
        start_window(10'b0000010000, 1'b0, 0);
        repeat (29) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("rw_busy",  32'(busy),  32'd0);
        chk("rw_valid", 32'(valid), 32'd0);
        chk("rw_out",   {cls, mx, tie}, 32'd0);

        // Reset during SCAN index 5 (cycle cs+70).
        start_window(10'b0000010000, 1'b0, 0);
        repeat (69) @(negedge clk);
        chk("rs_busy_pre", 32'(busy), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("rs_busy",  32'(busy),  32'd0);
        chk("rs_out",   {cls, mx, tie, valid}, 32'd0);
        n_valid = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid === 1'b1) n_valid++;
        end
        chk("rs_no_valid", 32'(n_valid), 32'd0);

        // start_i and rst_i together: reset wins.
        start_i = 1'b1; rst_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; rst_i = 1'b0;
        chk("sr_busy", 32'(busy), 32'd0);

        // All-zero window.
        start_window(10'b0000000000, 1'b1, 75);
        wait_result("zero", 200, 1'b0, 1'b0);
        @(negedge clk);

        // Saturation on the 300-cycle instance.
        start_s  = 1'b1;
        spikes_i = 10'b1000000000;
        en_i     = 1'b1;
        cs       = cyc;
        sb.push_back(model(10'b1000000000, 300, 311));
        @(negedge clk);
        start_s = 1'b0;
        wait_result("sat", 500, 1'b0, 1'b1);
        @(negedge clk);
        chk("sat_other_idle", 32'(busy), 32'd0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
